decode_ctrl: RTL
================

# decode_ctrl

Sequencer for the 16-bit instruction decode datapath. It accepts instruction words with their select bit over a valid/ready stream and buffers them in a small FIFO. It applies each word to the decode unit's `c`/`sel` inputs, holds them stable for a programmable settle time, then captures `out`/`Asel`. Captured results go out on a second valid/ready stream, so the decode unit is driven one word at a time and never sees an input change mid-evaluation.

## Interface
- `W`, 16: instruction and decode-result width.
- `DEPTH`, 4: input FIFO depth in words, power of two, minimum 2.
- `DEC_LAT`, 1: cycles the decode inputs are held before capture, minimum 1.
- `clk`  in  1: the single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `in_valid`  in  1: an input word is offered.
- `in_ready`  out  1: the block can accept a word.
- `in_word`  in  W: instruction word.
- `in_sel`  in  1: select bit travelling with the word.
- `dec_c`  out  W: registered drive to decode `c`.
- `dec_sel`  out  1: registered drive to decode `sel`.
- `dec_out`  in  W: decode result.
- `dec_asel`  in  1: decode `Asel` result.
- `out_valid`  out  1: a captured result is presented.
- `out_ready`  in  1: the sink accepts the result.
- `out_word`  out  W: captured `dec_out`.
- `out_asel`  out  1: captured `dec_asel`.
- `count`  out  $clog2(DEPTH)+1: FIFO occupancy.
- `busy`  out  1: high when state ≠ IDLE or `count` ≠ 0.

## Operation
- **FIFO**
  - A push happens on `in_valid && in_ready`. `in_ready` = !full, computed from registered `count`.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves `count` unchanged.
  - Pointers wrap modulo DEPTH.
  - A pushed word is visible to the FSM the following cycle. There is no fall-through.
- **FSM states:** IDLE, SETTLE, HOLD.
  - **IDLE:** if `count` ≠ 0, pop the head word. Load `dec_c`/`dec_sel`, set `lat_cnt` = DEC_LAT, go to SETTLE. Otherwise stay in IDLE.
  - **SETTLE:** decrement `lat_cnt` each cycle. On the cycle where `lat_cnt` = 1, register `dec_out`→`out_word` and `dec_asel`→`out_asel`, set `out_valid`, go to HOLD.
  - **HOLD:** `out_valid`, `out_word` and `out_asel` are held stable until `out_ready`.
    - On handshake with `count` ≠ 0: pop and load `dec_c`/`dec_sel` in the same cycle, clear `out_valid`, go to SETTLE.
    - On handshake with `count` = 0: clear `out_valid`, go to IDLE.
- `dec_c`/`dec_sel` change only on a pop; they keep their last value otherwise. The decode inputs are therefore stable for at least DEC_LAT cycles before capture.
- Words are processed strictly in order. None is dropped or duplicated.

## Timing
- **Reset values** (the cycle after `rst` is sampled high):
  - `in_ready`=0 while `rst` is high, 1 the first cycle after.
  - `out_valid`=0, `out_word`=0, `out_asel`=0, `dec_c`=0, `dec_sel`=0, `count`=0, `busy`=0, state=IDLE.
- **Reset mid-operation:** clears the FIFO, any in-flight word and any pending result. Nothing is emitted afterwards for words accepted before reset.
- **Latency:** a word accepted at edge 0 into an empty, idle block is popped at edge 1 (`dec_c` valid in cycle 2). `out_valid` rises in cycle 2+DEC_LAT (cycle 3 with DEC_LAT=1).
- **Throughput:** with `out_ready` held high, one result every DEC_LAT+1 cycles.
- **No combinational paths:**
  - `out_ready` to `in_ready`.
  - `in_valid` to any output.
  - `dec_out` to `out_word`.
- **Backpressure:** if `out_ready` is low in HOLD, the FIFO keeps accepting until full, then `in_ready`=0.

## Test plan
The bench uses a combinational decode stub: `dec_out` = `dec_c` ^ 16'hFFFF, `dec_asel` = `dec_sel`.
- **Single word:** reset, push word 16'h01FF with sel 0 at edge 0, `out_ready`=1 → `dec_c`=16'h01FF in cycle 2; `out_valid`=1 in cycle 3 with `out_word`=16'hFE00, `out_asel`=0; `busy`=0 in cycle 4.
- **Back-to-back stream:** push 16'h5555/0, 16'hEFE0/1, 16'hF008/1 on consecutive cycles, `out_ready`=1 → results 16'hAAAA/0, 16'h101F/1, 16'h0FF7/1, in order, spaced 2 cycles apart.
- **Backpressure to full:** `out_ready`=0, push 6 words → 5 accepted (1 in HOLD plus 4 in FIFO), `count`=4, `in_ready`=0. Release `out_ready` → all 5 results drain in order.
- **Simultaneous push/pop at full:** with `count`=4, drive `in_valid` in the same cycle as the HOLD handshake → push refused, `count`=3 next cycle, `in_ready`=1.
- **Reset mid-operation:** reset asserted in SETTLE with `count`=2 → next cycle `out_valid`=0, `count`=0, `dec_c`=0; no stale results appear afterwards.
- **DEC_LAT=3 build:** a single word gives `out_valid` in cycle 5. Change `dec_out` during SETTLE → the captured value is the one sampled in the final SETTLE cycle.

Source files
------------

// File: rtl/decode_ctrl.sv
// decode_ctrl: queues instruction words and drives the decode unit one word at a time.
// Pop one cycle after push, capture DEC_LAT cycles after the pop; in_ready falls only when the FIFO is full.
module decode_ctrl #(
    parameter int W       = 16,
    parameter int DEPTH   = 4,
    parameter int DEC_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_word,
    input  logic                   in_sel,
    output logic [W-1:0]           dec_c,
    output logic                   dec_sel,
    input  logic [W-1:0]           dec_out,
    input  logic                   dec_asel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_word,
    output logic                   out_asel,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(DEC_LAT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    logic [W:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [LW-1:0] lat_cnt;
    logic          push;
    logic          pop;
    logic          full;
    logic          has_word;

    // in_ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
    assign full     = (count == CW'(DEPTH));
    assign has_word = (count != '0);
    assign in_ready = !rst && !full;
    assign push     = in_valid && in_ready;
    assign pop      = has_word && ((state == IDLE) || ((state == HOLD) && out_ready));
    assign busy     = (state != IDLE) || has_word;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_sel, in_word};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            dec_c     <= '0;
            dec_sel   <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_asel  <= 1'b0;
        end else begin
            // Decode inputs move only on a pop, so they are stable for the whole settle window.
            if (pop) begin
                dec_c   <= mem[rd_ptr][W-1:0];
                dec_sel <= mem[rd_ptr][W];
                lat_cnt <= LW'(DEC_LAT);
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (lat_cnt == LW'(1)) begin
                        out_word  <= dec_out;
                        out_asel  <= dec_asel;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= pop ? SETTLE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
